// File: rtl/i2c_target_pkg.sv
// Shared definitions for the accelerometer-emulating I2C target.
// Contents: FSM state enum, register map addresses, sample sign-extension helper.
package i2c_target_pkg;

    localparam int unsigned SAMPLE_W   = 10;
    localparam int unsigned NUM_SHADOW = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] REG_DEVID     = 8'h00;
    localparam logic [7:0] REG_SHADOW_LO = 8'h2C;
    localparam logic [7:0] REG_SHADOW_HI = 8'h31;
    localparam logic [7:0] REG_DATAX0    = 8'h32;
    localparam logic [7:0] REG_DATAX1    = 8'h33;
    localparam logic [7:0] REG_DATAY0    = 8'h34;
    localparam logic [7:0] REG_DATAY1    = 8'h35;
    localparam logic [7:0] REG_DATAZ0    = 8'h36;
    localparam logic [7:0] REG_DATAZ1    = 8'h37;

    // 10-bit two's complement sample widened to the 16-bit register pair.
    function automatic logic [15:0] sext_sample(input logic [SAMPLE_W-1:0] v);
        return {{(16 - SAMPLE_W){v[SAMPLE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one I2C line: 2-flop synchronizer, optional glitch filter, edge detect.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (FILTER_LEN-sample filter).
// Ports: clk, rst (async, active-high), pin (raw line), level (conditioned value),
//        rise_c / fall_c (one-cycle edge flags on level).
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    if (FILTER_LEN == 0) begin : g_bad_len
        $error("i2c_line_filter: FILTER_LEN must be at least 1");
    end

    logic sync1;
    logic sync2;
    logic prev;

    // Lines idle high, so synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // Output follows the input only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Previous conditioned value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/i2c_accel_target.sv
// I2C target emulating the accelerometer register map (DEVID, shadow regs, X/Y/Z).
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (input glitch filter).
// Ports: CLOCK_50, RESET (async, active-high), I2C_SCL, I2C_SDA_IN, I2C_SDA_OE (1 = pull low),
//        AccelX/Y/Z + DataValid (sample input), RegWrAddr/RegWrData/RegWrStrobe (write
//        forwarding), Busy (addressed transaction in progress).
module i2c_accel_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h53,
    parameter logic [7:0]  DEVID_VAL  = 8'hE5,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                I2C_SCL,
    input  logic                I2C_SDA_IN,
    output logic                I2C_SDA_OE,
    input  logic [SAMPLE_W-1:0] AccelX,
    input  logic [SAMPLE_W-1:0] AccelY,
    input  logic [SAMPLE_W-1:0] AccelZ,
    input  logic                DataValid,
    output logic [7:0]          RegWrAddr,
    output logic [7:0]          RegWrData,
    output logic                RegWrStrobe,
    output logic                Busy
);

    logic scl_level, scl_rise_c, scl_fall_c;
    logic sda_level, sda_rise_c, sda_fall_c;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(CLOCK_50), .rst(RESET), .pin(I2C_SCL),
        .level(scl_level), .rise_c(scl_rise_c), .fall_c(scl_fall_c)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(CLOCK_50), .rst(RESET), .pin(I2C_SDA_IN),
        .level(sda_level), .rise_c(sda_rise_c), .fall_c(sda_fall_c)
    );

    logic start_c, stop_c;
    assign start_c = sda_fall_c & scl_level;
    assign stop_c  = sda_rise_c & scl_level;

    state_t state, state_d;
    logic [3:0] bit_cnt, bit_cnt_d;
    logic [7:0] rx, rx_d;
    logic [6:0] tx, tx_d;           // bits still to send after the one on the line
    logic [7:0] ptr, ptr_d;
    logic       ack_ok, ack_ok_d;
    logic       oe, oe_d;
    logic       busy, busy_d;
    logic       wr_fire, snap_load;

    logic [SAMPLE_W-1:0] hold_x, hold_y, hold_z;
    logic [SAMPLE_W-1:0] snap_x, snap_y, snap_z;
    logic [7:0]          shadow [NUM_SHADOW];
    logic [7:0]          strobe_q, wr_addr_q, wr_data_q;

    // Byte served for the current pointer, or the next one when an ACK is pending.
    logic [7:0]  rd_addr_c, rd_byte_c;
    logic [15:0] sx_c, sy_c, sz_c;

    assign sx_c = sext_sample(snap_x);
    assign sy_c = sext_sample(snap_y);
    assign sz_c = sext_sample(snap_z);
    assign rd_addr_c = (state == ST_RDATA_ACK) ? ptr + 8'd1 : ptr;

    always_comb begin
        rd_byte_c = 8'h00;
        case (rd_addr_c)
            REG_DEVID:             rd_byte_c = DEVID_VAL;
            REG_SHADOW_LO:         rd_byte_c = shadow[0];
            REG_SHADOW_LO + 8'd1:  rd_byte_c = shadow[1];
            REG_SHADOW_LO + 8'd2:  rd_byte_c = shadow[2];
            REG_SHADOW_LO + 8'd3:  rd_byte_c = shadow[3];
            REG_SHADOW_LO + 8'd4:  rd_byte_c = shadow[4];
            REG_SHADOW_HI:         rd_byte_c = shadow[5];
            REG_DATAX0:            rd_byte_c = sx_c[7:0];
            REG_DATAX1:            rd_byte_c = sx_c[15:8];
            REG_DATAY0:            rd_byte_c = sy_c[7:0];
            REG_DATAY1:            rd_byte_c = sy_c[15:8];
            REG_DATAZ0:            rd_byte_c = sz_c[7:0];
            REG_DATAZ1:            rd_byte_c = sz_c[15:8];
            default:               rd_byte_c = 8'h00;
        endcase
    end

    // Protocol state register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and bit-level control; bits sampled on SCL rise, SDA driven after SCL fall.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        rx_d      = rx;
        tx_d      = tx;
        ptr_d     = ptr;
        ack_ok_d  = ack_ok;
        oe_d      = oe;
        busy_d    = busy;
        wr_fire   = 1'b0;
        snap_load = 1'b0;

        if (stop_c) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_c) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
        end else begin
            if (scl_rise_c) begin
                if (state inside {ST_ADDR, ST_REG, ST_WDATA}) begin
                    rx_d      = {rx[6:0], sda_level};
                    bit_cnt_d = 4'(bit_cnt + 4'd1);
                end else if (state == ST_RDATA) begin
                    bit_cnt_d = 4'(bit_cnt + 4'd1);
                end else if (state == ST_RDATA_ACK) begin
                    ack_ok_d = ~sda_level;
                end
            end

            if (scl_fall_c) begin
                case (state)
                    ST_ADDR: if (bit_cnt == 4'd8) begin
                        if (rx[7:1] == DEV_ADDR) begin
                            state_d   = ST_ADDR_ACK;
                            oe_d      = 1'b1;
                            busy_d    = 1'b1;
                            snap_load = rx[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                    ST_REG: if (bit_cnt == 4'd8) begin
                        ptr_d   = rx;
                        state_d = ST_REG_ACK;
                        oe_d    = 1'b1;
                    end
                    ST_WDATA: if (bit_cnt == 4'd8) begin
                        state_d = ST_WDATA_ACK;
                        oe_d    = 1'b1;
                        wr_fire = 1'b1;
                        ptr_d   = ptr + 8'd1;
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt_d = 4'd0;
                        if (rx[0]) begin
                            state_d = ST_RDATA;
                            tx_d    = rd_byte_c[6:0];
                            oe_d    = ~rd_byte_c[7];
                        end else begin
                            state_d = ST_REG;
                            oe_d    = 1'b0;
                        end
                    end
                    ST_REG_ACK, ST_WDATA_ACK: begin
                        state_d   = ST_WDATA;
                        bit_cnt_d = 4'd0;
                        oe_d      = 1'b0;
                    end
                    ST_RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            state_d = ST_RDATA_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d = ~tx[6];
                            tx_d = {tx[5:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (ack_ok) begin
                            state_d   = ST_RDATA;
                            ptr_d     = ptr + 8'd1;
                            tx_d      = rd_byte_c[6:0];
                            oe_d      = ~rd_byte_c[7];
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_IGNORE;
                            oe_d    = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers, sample holding/snapshot and write forwarding.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            bit_cnt   <= 4'd0;
            rx        <= 8'h00;
            tx        <= 7'h00;
            ptr       <= 8'h00;
            ack_ok    <= 1'b0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            strobe_q  <= 8'h00;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
            hold_x    <= '0;
            hold_y    <= '0;
            hold_z    <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_z    <= '0;
            for (int i = 0; i < NUM_SHADOW; i++) shadow[i] <= 8'h00;
        end else begin
            bit_cnt  <= bit_cnt_d;
            rx       <= rx_d;
            tx       <= tx_d;
            ptr      <= ptr_d;
            ack_ok   <= ack_ok_d;
            oe       <= oe_d;
            busy     <= busy_d;
            strobe_q <= {7'h00, wr_fire};
            if (wr_fire) begin
                wr_addr_q <= ptr;
                wr_data_q <= rx;
            end
            for (int i = 0; i < NUM_SHADOW; i++) begin
                if (wr_fire && ptr == REG_SHADOW_LO + 8'(i)) shadow[i] <= rx;
            end
            if (DataValid) begin
                hold_x <= AccelX;
                hold_y <= AccelY;
                hold_z <= AccelZ;
            end
            if (snap_load) begin
                snap_x <= hold_x;
                snap_y <= hold_y;
                snap_z <= hold_z;
            end
        end
    end

    assign I2C_SDA_OE  = oe;
    assign Busy        = busy;
    assign RegWrStrobe = strobe_q[0];
    assign RegWrAddr   = wr_addr_q;
    assign RegWrData   = wr_data_q;

endmodule

// File: tb/tb_i2c_accel_target.sv
// Directed bench for i2c_accel_target: bit-banged I2C initiator, queue scoreboards for
// read bytes and forwarded writes, immediate-assertion checks.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (adds an SCL glitch step).
module tb_i2c_accel_target;

    localparam int unsigned Q = 10;    // quarter SCL period in clocks

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       oe;
    logic [9:0] ax = '0, ay = '0, az = '0;
    logic       dv = 1'b0;
    logic [7:0] wr_addr, wr_data;
    logic       wr_stb, busy;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];

    assign sda_bus = m_sda & ~oe;

    always #10 clk = ~clk;

    i2c_accel_target dut (
        .CLOCK_50(clk), .RESET(rst), .I2C_SCL(m_scl), .I2C_SDA_IN(sda_bus),
        .I2C_SDA_OE(oe), .AccelX(ax), .AccelY(ay), .AccelZ(az), .DataValid(dv),
        .RegWrAddr(wr_addr), .RegWrData(wr_data), .RegWrStrobe(wr_stb), .Busy(busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Forwarded writes are popped from the scoreboard as the strobe appears.
    always @(negedge clk) begin
        if (!rst && wr_stb) begin
            logic [15:0] e;
            strobe_cnt++;
            e = (wr_q.size() != 0) ? wr_q.pop_front() : 16'bx;
            check("reg_write", {wr_addr, wr_data}, e);
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b1; wait_q(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wait_q(Q);
            m_scl = 1'b1; wait_q(2 * Q);
            m_scl = 1'b0; wait_q(Q);
        end
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        ack = ~sda_bus; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q(Q);
            m_scl = 1'b1; wait_q(Q);
            b[i] = sda_bus; wait_q(Q);
            m_scl = 1'b0; wait_q(Q);
        end
        m_sda = nack; wait_q(Q);
        m_scl = 1'b1; wait_q(2 * Q);
        m_scl = 1'b0;
        m_sda = 1'b1; wait_q(Q);
    endtask

    task automatic wr_chk(input logic [7:0] b, input string tag);
        logic a;
        write_byte(b, a);
        check(tag, {15'd0, a}, 16'd1);
    endtask

    task automatic rd_chk(input logic nack, input string tag);
        logic [7:0] b, e;
        read_byte(nack, b);
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'bx;
        check(tag, {8'd0, b}, {8'd0, e});
    endtask

    task automatic pulse_dv(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
        ax = x; ay = y; az = z;
        @(negedge clk) dv = 1'b1;
        @(negedge clk) dv = 1'b0;
    endtask

    // Pointer set, repeated START, read address; leaves the target in a read.
    task automatic open_read(input logic [7:0] reg_addr);
        i2c_start();
        wr_chk(8'hA6, "ack_addr_w");
        wr_chk(reg_addr, "ack_ptr");
        i2c_start();
        wr_chk(8'hA7, "ack_addr_r");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic a;
        wait_q(4);
        rst = 1'b0;
        wait_q(4);
        check("rst_oe",     {15'd0, oe},     16'd0);
        check("rst_busy",   {15'd0, busy},   16'd0);
        check("rst_strobe", {15'd0, wr_stb}, 16'd0);
        check("rst_wraddr", {8'd0, wr_addr}, 16'd0);
        check("rst_wrdata", {8'd0, wr_data}, 16'd0);

        pulse_dv(10'h3FF, 10'h001, 10'h200);

        // Write 0x08 to 0x2D.
        i2c_start();
        wr_chk(8'hA6, "t1_ack_addr");
        wr_chk(8'h2D, "t1_ack_reg");
        wr_q.push_back({8'h2D, 8'h08});
        wr_chk(8'h08, "t1_ack_data");
        i2c_stop();

        // DEVID read, NACK, STOP.
        open_read(8'h00);
        check("t2_busy_on", {15'd0, busy}, 16'd1);
        rd_q.push_back(8'hE5);
        rd_chk(1'b1, "t2_devid");
        wait_q(Q);
        check("t2_oe_released", {15'd0, oe}, 16'd0);
        i2c_stop();
        check("t2_busy_off", {15'd0, busy}, 16'd0);

        // Shadow readback.
        open_read(8'h2D);
        rd_q.push_back(8'h08);
        rd_chk(1'b1, "t1_readback");
        i2c_stop();

        // Burst of the sign-extended samples.
        open_read(8'h32);
        rd_q.push_back(8'hFF); rd_q.push_back(8'hFF); rd_q.push_back(8'h01);
        rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'hFE);
        for (int i = 0; i < 6; i++) rd_chk(i == 5, "t3_burst");
        i2c_stop();

        // Same burst with a new sample arriving mid-transfer.
        open_read(8'h32);
        rd_q.push_back(8'hFF); rd_q.push_back(8'hFF); rd_q.push_back(8'h01);
        rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'hFE);
        for (int i = 0; i < 6; i++) begin
            rd_chk(i == 5, "t4_coherent");
            if (i == 1) pulse_dv(10'h005, 10'h001, 10'h200);
        end
        i2c_stop();
        open_read(8'h32);
        rd_q.push_back(8'h05); rd_q.push_back(8'h00);
        rd_chk(1'b0, "t4_new_x0");
        rd_chk(1'b1, "t4_new_x1");
        i2c_stop();

        // Foreign address is ignored.
        i2c_start();
        write_byte(8'hA8, a);
        check("t5_no_ack", {15'd0, a}, 16'd0);
        check("t5_oe", {15'd0, oe}, 16'd0);
        check("t5_busy", {15'd0, busy}, 16'd0);
        i2c_stop();
        i2c_start();
        wr_chk(8'hA6, "t5_ack_after");
        wr_chk(8'h10, "t5_ack_reg");
        i2c_stop();
        check("t5_strobe_cnt", 16'(strobe_cnt), 16'd1);

        // Reset while the target drives a 0 data bit (register 0x10 reads 0x00).
        open_read(8'h10);
        wait_q(2);
        check("t6_oe_driving", {15'd0, oe}, 16'd1);
        rst = 1'b1;
        #1;
        check("t6_oe_async_rst", {15'd0, oe}, 16'd0);
        wait_q(3);
        rst = 1'b0;
        wait_q(2);
        check("t6_busy_rst", {15'd0, busy}, 16'd0);
        i2c_stop();
        i2c_start();
        wr_chk(8'hA6, "t6_ack_addr");
        wr_chk(8'h2C, "t6_ack_reg");
        wr_q.push_back({8'h2C, 8'h55});
        wr_chk(8'h55, "t6_ack_data");
        i2c_stop();
        open_read(8'h2C);
        rd_q.push_back(8'h55);
        rd_chk(1'b1, "t6_readback");
        i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // A 2-cycle SCL pulse must not count as a bit.
        i2c_start();
        m_scl = 1'b1; wait_q(2);
        m_scl = 1'b0; wait_q(Q);
        wr_chk(8'hA6, "t6_glitch_ack");
        i2c_stop();
`endif

        wait_q(Q);
        check("final_strobe_cnt", 16'(strobe_cnt), 16'd2);
        check("final_wr_q_empty", 16'(wr_q.size()), 16'd0);
        check("final_rd_q_empty", 16'(rd_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_accel_target.md
Name: i2c_accel_target

Overview:
- I2C target (responder) that emulates the on-board accelerometer's register map. It answers the existing IMU I2C initiator so that controller can be exercised in simulation and on hardware loopback without the real sensor.
- Samples SCL/SDA on CLOCK_50 and drives SDA open-drain through an output enable.
- Serves sign-extended X/Y/Z samples from its inputs.
- Forwards register writes to the fabric through a strobe interface.

Parameters:
DEV_ADDR, 7'h53, 7-bit target address matched in the address phase
DEVID_VAL, 8'hE5, value returned for register 0x00
FILTER_LEN, 4, consecutive equal samples required by the glitch filter (only used with the optional feature)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET  input  1  asynchronous, active-high reset
I2C_SCL  input  1  bus clock; the target never stretches SCL
I2C_SDA_IN  input  1  bus data as seen on the pin
I2C_SDA_OE  output  1  1 = pull SDA low; the top level builds the inout as OE ? 0 : Z
AccelX  input  10  signed X sample
AccelY  input  10  signed Y sample
AccelZ  input  10  signed Z sample
DataValid  input  1  1-cycle pulse: new X/Y/Z sample available
RegWrAddr  output  8  register pointer of the last written byte
RegWrData  output  8  last written byte
RegWrStrobe  output  1  1-cycle pulse per accepted data byte
Busy  output  1  1 from an addressed START until STOP

Behaviour:
- Clock/reset: one clock domain (CLOCK_50). Reset is asynchronous and active-high.
- Reset values: I2C_SDA_OE=0, RegWrStrobe=0, RegWrAddr=0, RegWrData=0, Busy=0, state=IDLE, pointer=0, holding/snapshot registers=0, shadow registers=0.
- Input sync: SCL and SDA each pass through a 2-flop synchronizer, then an edge detector.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising.
  - SDA_OE changes only on the cycle after a detected SCL falling edge (3-cycle latency from the pin).
- State machine: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Transitions:
  - START from any state -> ADDR, bit counter cleared (repeated START allowed).
  - STOP from any state -> IDLE, OE=0, Busy=0.
  - ADDR, after 8 bits, address match:
    - R/W=0 -> ADDR_ACK -> REG.
    - R/W=1 -> ADDR_ACK -> RDATA.
  - ADDR, after 8 bits, no match -> IGNORE (no ACK) until the next START/STOP.
  - REG: the 8-bit byte loads the pointer, ACK, then -> WDATA.
  - WDATA: byte ACKed; RegWrStrobe pulses on the ACK cycle with the current pointer/data; writes to 0x2C..0x31 update the shadow register; pointer += 1; -> WDATA.
  - RDATA: shift out MSB first; -> RDATA_ACK, sampling the initiator's bit.
    - ACK -> pointer += 1, load the next byte, -> RDATA.
    - NACK -> IGNORE (released) until STOP/START.
- ACK drive: OE=1 from the SCL fall after bit 8 until the SCL fall after bit 9.
- Read map:
  - 0x00 -> DEVID_VAL.
  - 0x2C..0x31 -> shadow registers.
  - 0x32/0x33 = X low/high byte, 0x34/0x35 = Y, 0x36/0x37 = Z. Each 10-bit sample is sign-extended to 16 bits, little-endian.
  - All other addresses -> 8'h00.
- Pointer: 8-bit, wraps 0xFF -> 0x00.
- Coherency: DataValid loads the holding registers. The snapshot copies holding on the ADDR_ACK of a read. A multi-byte read returns one sample set even if DataValid arrives mid-transfer.
- Busy: set on address match, cleared on STOP.
- Reset mid-transfer: OE released immediately (asynchronous). The target then ignores the bus until the next START.

Optional Feature:
I2C_TARGET_GLITCH_FILTER_EN
- Defined: after synchronization, each line's filtered value changes only after FILTER_LEN consecutive equal samples. All edge/START/STOP detection uses the filtered values. Added latency is FILTER_LEN cycles.
- Undefined: 2-flop synchronizer only; FILTER_LEN is ignored.

Decomposition:
- Shared package i2c_target_pkg:
  - state enum;
  - register address constants (REG_DEVID=8'h00, REG_SHADOW_LO=8'h2C, REG_SHADOW_HI=8'h31, REG_DATAX0=8'h32 .. REG_DATAZ1=8'h37).
- One sub-module: i2c_line_filter, instantiated once per line. It contains the synchronizer, the optional filter and the rise/fall outputs.

Test Plan:
1. Write to 0x53: addr 0xA6, reg 0x2D, data 0x08, STOP -> three ACKs; one RegWrStrobe with Addr=0x2D, Data=0x08. A later read of 0x2D returns 0x08.
2. Read DEVID: write 0x00, repeated START, 0xA7, read 1 byte, NACK -> byte 0xE5; OE released after the NACK; Busy falls at STOP.
3. Burst read from 0x32 of 6 bytes with AccelX=10'h3FF, Y=10'h001, Z=10'h200 -> FF FF 01 00 00 FE.
4. Same burst read with DataValid pulsed (new X=10'h005) after byte 2 -> all 6 bytes still from the old snapshot; the next transaction returns 05 00.
5. Address 0xA8 (0x54) -> no ACK (OE stays 0), no strobe, Busy=0; the next START to 0xA6 is ACKed.
6. RESET asserted while driving a 0 read bit -> OE=0 in the same cycle. A write of 0x55 to 0x2C then succeeds. With I2C_TARGET_GLITCH_FILTER_EN defined, a 2-cycle SCL pulse produces no bit.
